// File: rtl/ir_regiester.sv
// rtl/ir_regiester.sv - instruction register, program counter and address select datapath
module ir_regiester #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic                       clock,
  input  logic                       Reset,
  input  logic                       IRload,
  input  logic                       JMPmux,
  input  logic                       PCload,
  input  logic                       Meminst,
  output logic [DATA_W-ADDR_W-1:0]   IR,
  output logic [DATA_W-1:0]          Q_IR,
  input  logic [DATA_W-1:0]          Q_ram,
  output logic [ADDR_W-1:0]          D_PC,
  output logic [ADDR_W-1:0]          Q_Incr,
  output logic [ADDR_W-1:0]          Q_PC,
  output logic [ADDR_W-1:0]          Q_Meminst
);

  localparam int OP_W = DATA_W - ADDR_W;

  logic [ADDR_W-1:0] addr_field;

  assign IR         = Q_IR[DATA_W-1 -: OP_W];
  assign addr_field = Q_IR[ADDR_W-1:0];

  // Address-width add wraps naturally at 2**ADDR_W
  assign Q_Incr = Q_PC + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Next-PC select; an unknown JMPmux falls to the increment path
  always_comb begin
    D_PC = Q_Incr;
    if (JMPmux == 1'b1) begin
      D_PC = addr_field;
    end else begin
      D_PC = Q_Incr;
    end
  end

  // Memory address select; an unknown Meminst falls to the PC path
  always_comb begin
    Q_Meminst = Q_PC;
    if (Meminst == 1'b1) begin
      Q_Meminst = addr_field;
    end else begin
      Q_Meminst = Q_PC;
    end
  end

  // Instruction register: reset wins over load, otherwise hold
  always_ff @(posedge clock) begin
    if (Reset) begin
      Q_IR <= '0;
    end else if (IRload == 1'b1) begin
      Q_IR <= Q_ram;
    end
  end

  // Program counter: D_PC sees the pre-edge Q_IR, so a jump lags an IR load by one cycle
  always_ff @(posedge clock) begin
    if (Reset) begin
      Q_PC <= '0;
    end else if (PCload == 1'b1) begin
      Q_PC <= D_PC;
    end
  end

endmodule

// File: tb/tb_ir_regiester.sv
// tb/tb_ir_regiester.sv - scoreboard bench for ir_regiester
module tb_ir_regiester;

  logic       clock;
  logic       Reset;
  logic       IRload;
  logic       JMPmux;
  logic       PCload;
  logic       Meminst;
  logic [2:0] IR;
  logic [7:0] Q_IR;
  logic [7:0] Q_ram;
  logic [4:0] D_PC;
  logic [4:0] Q_Incr;
  logic [4:0] Q_PC;
  logic [4:0] Q_Meminst;

  typedef struct {
    string      name;
    logic [2:0] ir;
    logic [7:0] q_ir;
    logic [4:0] d_pc;
    logic [4:0] q_incr;
    logic [4:0] q_pc;
    logic [4:0] q_meminst;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  ir_regiester #(.DATA_W(8), .ADDR_W(5)) dut (
    .clock     (clock),
    .Reset     (Reset),
    .IRload    (IRload),
    .JMPmux    (JMPmux),
    .PCload    (PCload),
    .Meminst   (Meminst),
    .IR        (IR),
    .Q_IR      (Q_IR),
    .Q_ram     (Q_ram),
    .D_PC      (D_PC),
    .Q_Incr    (Q_Incr),
    .Q_PC      (Q_PC),
    .Q_Meminst (Q_Meminst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one vector just after a rising edge and queue the outputs it should show before the next edge
  task automatic vec(input string name, input logic rst, input logic irl, input logic jmp,
                     input logic pcl, input logic mem, input logic [7:0] ram,
                     input logic [2:0] e_ir, input logic [7:0] e_qir, input logic [4:0] e_dpc,
                     input logic [4:0] e_incr, input logic [4:0] e_pc, input logic [4:0] e_mem);
    exp_t e;
    @(posedge clock);
    #1;
    Reset = rst; IRload = irl; JMPmux = jmp; PCload = pcl; Meminst = mem; Q_ram = ram;
    e.name = name; e.ir = e_ir; e.q_ir = e_qir; e.d_pc = e_dpc;
    e.q_incr = e_incr; e.q_pc = e_pc; e.q_meminst = e_mem;
    exp_q.push_back(e);
  endtask

  // Monitor: pop and compare mid-cycle whenever an expectation is pending
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (IR !== e.ir) begin
          n_bad++; $display("FAIL %s IR got %h want %h", e.name, IR, e.ir);
        end
        if (Q_IR !== e.q_ir) begin
          n_bad++; $display("FAIL %s Q_IR got %h want %h", e.name, Q_IR, e.q_ir);
        end
        if (D_PC !== e.d_pc) begin
          n_bad++; $display("FAIL %s D_PC got %0d want %0d", e.name, D_PC, e.d_pc);
        end
        if (Q_Incr !== e.q_incr) begin
          n_bad++; $display("FAIL %s Q_Incr got %0d want %0d", e.name, Q_Incr, e.q_incr);
        end
        if (Q_PC !== e.q_pc) begin
          n_bad++; $display("FAIL %s Q_PC got %0d want %0d", e.name, Q_PC, e.q_pc);
        end
        if (Q_Meminst !== e.q_meminst) begin
          n_bad++; $display("FAIL %s Q_Meminst got %0d want %0d", e.name, Q_Meminst, e.q_meminst);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    Reset = 1'b1; IRload = 1'b0; JMPmux = 1'b0; PCload = 1'b0; Meminst = 1'b0; Q_ram = 8'h00;
    //   name              rst irl jmp pcl mem ram    IR    Q_IR   D_PC   Incr   Q_PC   Meminst
    vec("reset",           0,  0,  0,  0,  0,  8'h00, 3'd0, 8'h00, 5'd1,  5'd1,  5'd0,  5'd0);
    vec("reset_jmp",       0,  0,  1,  0,  0,  8'h00, 3'd0, 8'h00, 5'd0,  5'd1,  5'd0,  5'd0);
    vec("load1_pre",       0,  1,  1,  1,  1,  8'h01, 3'd0, 8'h00, 5'd0,  5'd1,  5'd0,  5'd0);
    vec("load1_edge1",     0,  1,  1,  1,  1,  8'h01, 3'd0, 8'h01, 5'd1,  5'd1,  5'd0,  5'd1);
    vec("load1_edge2",     0,  0,  0,  1,  1,  8'h01, 3'd0, 8'h01, 5'd2,  5'd2,  5'd1,  5'd1);
    vec("incr_to2",        0,  0,  0,  0,  1,  8'h0F, 3'd0, 8'h01, 5'd3,  5'd3,  5'd2,  5'd1);
    vec("hold_memsel_pc",  0,  0,  0,  0,  0,  8'h0F, 3'd0, 8'h01, 5'd3,  5'd3,  5'd2,  5'd2);
    vec("ir_e7_pre",       0,  1,  1,  0,  0,  8'hE7, 3'd0, 8'h01, 5'd1,  5'd3,  5'd2,  5'd2);
    vec("ir_e7",           0,  0,  1,  1,  1,  8'hE7, 3'd7, 8'hE7, 5'd7,  5'd3,  5'd2,  5'd7);
    vec("jump7",           0,  1,  1,  0,  0,  8'h1F, 3'd7, 8'hE7, 5'd7,  5'd8,  5'd7,  5'd7);
    vec("jump31_pre",      0,  0,  1,  1,  1,  8'h1F, 3'd0, 8'h1F, 5'd31, 5'd8,  5'd7,  5'd31);
    vec("wrap_pre",        0,  0,  0,  1,  0,  8'h1F, 3'd0, 8'h1F, 5'd0,  5'd0,  5'd31, 5'd31);
    vec("wrapped",         0,  0,  0,  0,  0,  8'h1F, 3'd0, 8'h1F, 5'd1,  5'd1,  5'd0,  5'd0);
    vec("rst_midop_pre",   1,  1,  1,  1,  1,  8'hAA, 3'd0, 8'h1F, 5'd31, 5'd1,  5'd0,  5'd31);
    vec("rst_override",    0,  0,  1,  0,  1,  8'hAA, 3'd0, 8'h00, 5'd0,  5'd1,  5'd0,  5'd0);
    vec("x_ctrl_not_one",  0,  0,  1'bx, 0, 1'bx, 8'hAA, 3'd0, 8'h00, 5'd1, 5'd1, 5'd0, 5'd0);
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clock);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ir_regiester.md
IR_REGIESTER -- requirements
Module: ir_regiester

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning instruction/memory word width.
REQ-002 The module SHALL have parameter ADDR_W, default 5, meaning PC/address width; opcode width SHALL be DATA_W-ADDR_W (3).
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port IRload, input, 1 bit: instruction register load enable.
REQ-006 The module SHALL have port JMPmux, input, 1 bit: next-PC select (1 = jump target, 0 = increment).
REQ-007 The module SHALL have port PCload, input, 1 bit: program counter load enable.
REQ-008 The module SHALL have port Meminst, input, 1 bit: memory-address select (1 = IR address field, 0 = PC).
REQ-009 The module SHALL have port IR, output, 3 bits: opcode field, Q_IR[7:5].
REQ-010 The module SHALL have port Q_IR, output, 8 bits: instruction register contents.
REQ-011 The module SHALL have port Q_ram, input, 8 bits: memory read data.
REQ-012 The module SHALL have port D_PC, output, 5 bits: next-PC value.
REQ-013 The module SHALL have port Q_Incr, output, 5 bits: Q_PC + 1.
REQ-014 The module SHALL have port Q_PC, output, 5 bits: program counter.
REQ-015 The module SHALL have port Q_Meminst, output, 5 bits: memory address.
REQ-016 Ports SHALL appear in the order clock, Reset, IRload, JMPmux, PCload, Meminst, IR, Q_IR, Q_ram, D_PC, Q_Incr, Q_PC, Q_Meminst.

Function
REQ-017 On a rising clock edge with Reset=0 and IRload=1, Q_IR SHALL load Q_ram; with IRload=0 it SHALL hold.
REQ-018 IR SHALL be combinationally Q_IR[7:5]; the address field SHALL be Q_IR[4:0].
REQ-019 Q_Incr SHALL be combinationally Q_PC + 1 modulo 32; 31 SHALL wrap to 0.
REQ-020 D_PC SHALL be combinationally Q_IR[4:0] when JMPmux=1, else Q_Incr.
REQ-021 On a rising clock edge with Reset=0 and PCload=1, Q_PC SHALL load D_PC; with PCload=0 it SHALL hold.
REQ-022 When IRload=1 and PCload=1 in the same cycle, both registers SHALL update; D_PC SHALL use the pre-edge Q_IR, giving one-cycle latency from IR load to jump target.
REQ-023 Q_Meminst SHALL be combinationally Q_IR[4:0] when Meminst=1, else Q_PC.
REQ-024 Any X/unknown on a control input SHALL NOT be interpreted as 1; the implementation SHALL use explicit if/else muxing.

Reset
REQ-025 When Reset=1 at a rising edge, Q_IR SHALL become 8'h00 and Q_PC SHALL become 5'd0, overriding IRload/PCload.
REQ-026 After reset, IR SHALL be 0, Q_Incr 1, D_PC 1 (JMPmux=0) or 0 (JMPmux=1), and Q_Meminst 0.
REQ-027 Reset asserted mid-operation SHALL take effect at the next edge only; between edges outputs SHALL follow the combinational rules.

Verification
REQ-028 Reset=1 for one edge -> Q_IR=00, Q_PC=0, Q_Incr=1, IR=0.
REQ-029 Q_ram=01, IRload=1, JMPmux=1, PCload=1, Meminst=1 for 2 edges -> edge 1: Q_IR=01, Q_PC=0; edge 2: Q_PC=1, Q_Meminst=1.
REQ-030 Q_IR=01, Q_PC=1, JMPmux=0, PCload=1 -> D_PC=2; after the edge Q_PC=2, Q_Incr=3.
REQ-031 IRload=0, PCload=0, Q_ram changes to 0F -> Q_IR and Q_PC held; Meminst 1->0 switches Q_Meminst from Q_IR[4:0] to Q_PC.
REQ-032 Q_ram=E7, IRload=1 -> IR=3'b111, Q_IR[4:0]=7; JMPmux=1, PCload=1 -> Q_PC=7.
REQ-033 Q_PC=31, JMPmux=0, PCload=1 -> Q_Incr=0 and Q_PC wraps to 0.
